// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, FSM encoding and memory-enable codes for the
//               cpu_sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int CPU_ADDR_W = 5;
    localparam int CPU_DATA_W = 8;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_LOAD_IR = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_OP_LOAD = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    localparam logic [1:0] MEM_EN_ON  = 2'b01;
    localparam logic [1:0] MEM_EN_OFF = 2'b00;

    // Opcodes that need a second memory read before they can retire.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
// Module      : cpu_alu
// Description : Combinational accumulator update for ADD/AND/XOR/LDA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = i_operand;
        case (i_op)
            OP_ADD:  o_result = i_acc + i_operand;
            OP_AND:  o_result = i_acc & i_operand;
            OP_XOR:  o_result = i_acc ^ i_operand;
            default: o_result = i_operand;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle fetch/decode/execute sequencer driving a 32x8
//               memory with registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
    parameter int ADDR_W   = cpu_pkg::CPU_ADDR_W,
    parameter int DATA_W   = cpu_pkg::CPU_DATA_W,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_rd_en,
    output logic [1:0]        mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic              halted,
    output logic              retire
);

    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_acc;

    logic [2:0]        w_op;
    logic [ADDR_W-1:0] w_opnd_addr;
    logic [DATA_W-1:0] w_alu_result;

    assign w_op        = r_ir[DATA_W-1 -: 3];
    assign w_opnd_addr = r_ir[ADDR_W-1:0];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op      (w_op),
        .i_acc     (r_acc),
        .i_operand (mem_rdata),
        .o_result  (w_alu_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= C_RESET_PC;
            r_ir    <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_LOAD_IR;
                S_LOAD_IR: begin
                    r_ir    <= mem_rdata;
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        OP_HLT: r_state <= S_HALT;
                        OP_SKZ: begin
                            if (r_acc == '0) r_pc <= r_pc + ADDR_W'(1);
                            r_state <= S_FETCH;
                        end
                        OP_JMP: begin
                            r_pc    <= w_opnd_addr;
                            r_state <= S_FETCH;
                        end
                        OP_STO:  r_state <= S_FETCH;
                        default: r_state <= S_OP_LOAD;
                    endcase
                end
                S_OP_LOAD: begin
                    r_acc   <= w_alu_result;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Memory controls depend only on registered state so the read data
    // never feeds back into the address/enable path.
    always_comb begin
        mem_addr  = r_pc;
        mem_rd_en = MEM_EN_OFF;
        mem_wr_en = MEM_EN_OFF;
        retire    = 1'b0;
        case (r_state)
            S_FETCH: mem_rd_en = MEM_EN_ON;
            S_EXEC: begin
                mem_addr = w_opnd_addr;
                if (w_op == OP_STO) begin
                    mem_wr_en = MEM_EN_ON;
                end else if (is_mem_op(w_op)) begin
                    mem_rd_en = MEM_EN_ON;
                end
                retire = !is_mem_op(w_op);
            end
            S_OP_LOAD: begin
                mem_addr = w_opnd_addr;
                retire   = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            mem_rd_en = MEM_EN_OFF;
            mem_wr_en = MEM_EN_OFF;
            retire    = 1'b0;
        end
    end

    assign mem_wdata = r_acc;
    assign pc_out    = r_pc;
    assign acc_out   = r_acc;
    assign ir_out    = r_ir;
    assign halted    = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench: 32x8 memory plus an instruction-level
//               reference interpreter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] mem_addr;
    logic [1:0] mem_rd_en;
    logic [1:0] mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [4:0] pc_out;
    logic [7:0] acc_out;
    logic [7:0] ir_out;
    logic       halted;
    logic       retire;

    logic [7:0] mem [32];

    int ref_mem [32];
    int ref_pc, ref_acc, ref_ir;
    bit ref_halted;

    int checks = 0;
    int failures = 0;
    int retires = 0;
    int cyc_total = 0;

    always #5 clock = ~clock;

    cpu_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pc_out    (pc_out),
        .acc_out   (acc_out),
        .ir_out    (ir_out),
        .halted    (halted),
        .retire    (retire)
    );

    always @(posedge clock) begin
        if (mem_rd_en == 2'b01) mem_rdata <= mem[mem_addr];
        if (mem_wr_en == 2'b01) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_en();
        logic ok;
        ok = (mem_rd_en == 2'b00 || mem_rd_en == 2'b01) &&
             (mem_wr_en == 2'b00 || mem_wr_en == 2'b01) &&
             !(mem_rd_en == 2'b01 && mem_wr_en == 2'b01);
        chk("en_legal", {31'd0, ok}, 32'd1);
    endtask

    task automatic load(input int idx, input int val);
        mem[idx]     = val[7:0];
        ref_mem[idx] = val & 255;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) load(i, 0);
    endtask

    task automatic ref_init();
        ref_pc = 0; ref_acc = 0; ref_ir = 0; ref_halted = 0;
        retires = 0; cyc_total = 0;
    endtask

    // Executes one instruction at ISA level; returns its cycle cost.
    task automatic ref_exec(output int cost);
        int op, a;
        ref_ir = ref_mem[ref_pc];
        ref_pc = (ref_pc + 1) % 32;
        op = ref_ir / 32;
        a  = ref_ir % 32;
        cost = 3;
        case (op)
            0: ref_halted = 1;
            1: if (ref_acc == 0) ref_pc = (ref_pc + 1) % 32;
            2: begin ref_acc = (ref_acc + ref_mem[a]) % 256; cost = 4; end
            3: begin ref_acc = ref_acc & ref_mem[a]; cost = 4; end
            4: begin ref_acc = ref_acc ^ ref_mem[a]; cost = 4; end
            5: begin ref_acc = ref_mem[a]; cost = 4; end
            6: ref_mem[a] = ref_acc;
            default: ref_pc = a;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_rd", mem_rd_en, 0);
        chk("rst_wr", mem_wr_en, 0);
        @(negedge clock);
        chk("rst_rd2", mem_rd_en, 0);
        chk("rst_wr2", mem_wr_en, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_ir", ir_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        ref_init();
        #1;
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_rd", mem_rd_en, 1);
    endtask

    // Called while sampling the first cycle of an instruction.
    task automatic run_instrs(input int n);
        for (int k = 0; k < n && !ref_halted; k++) begin
            int cyc, exp_cyc, ins, a;
            ins = ref_mem[ref_pc];
            a   = ins % 32;
            chk("fetch_addr", mem_addr, ref_pc);
            chk("fetch_rd", mem_rd_en, 1);
            chk("fetch_wr", mem_wr_en, 0);
            cyc = 1;
            while (retire !== 1'b1 && cyc < 8) begin
                chk_en();
                @(negedge clock);
                cyc++;
            end
            chk_en();
            if (ins / 32 == 6) begin
                chk("sto_wr", mem_wr_en, 1);
                chk("sto_addr", mem_addr, a);
                chk("sto_data", mem_wdata, ref_acc);
            end
            ref_exec(exp_cyc);
            chk("cycles", cyc, exp_cyc);
            retires++;
            cyc_total += cyc;
            @(negedge clock);
            chk("pc", pc_out, ref_pc);
            chk("acc", acc_out, ref_acc);
            chk("ir", ir_out, ref_ir);
            chk("halted", halted, ref_halted);
        end
    endtask

    task automatic mem_compare();
        for (int i = 0; i < 32; i++) chk("mem", mem[i], ref_mem[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Directed program: LDA/ADD(wrap)/STO/HLT, then halt hold.
        do_reset();
        clear_mem();
        load(0, 8'hAA); load(1, 8'h4B); load(2, 8'hCC); load(3, 8'h00);
        load(10, 8'h0F); load(11, 8'hF5);
        release_reset();
        run_instrs(10);
        chk("p2_acc", acc_out, 8'h04);
        chk("p2_mem12", mem[12], 8'h04);
        chk("p2_pc", pc_out, 4);
        chk("p2_retires", retires, 4);
        chk("p2_cycles", cyc_total, 14);
        chk("p2_halted", halted, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("hold_rd", mem_rd_en, 0);
            chk("hold_wr", mem_wr_en, 0);
            chk("hold_pc", pc_out, ref_pc);
            chk("hold_acc", acc_out, ref_acc);
            chk("hold_ir", ir_out, ref_ir);
            chk("hold_retire", retire, 0);
            chk("hold_halted", halted, 1);
        end

        // SKZ with acc==0 skips.
        do_reset();
        clear_mem();
        load(0, 8'hE5); load(5, 8'h20); load(6, 8'h00); load(7, 8'h00);
        release_reset();
        run_instrs(2);
        chk("skz0_pc", pc_out, 7);

        // SKZ with acc==1 does not skip.
        do_reset();
        clear_mem();
        load(0, 8'hB4); load(20, 8'h01); load(1, 8'hE5);
        load(5, 8'h20); load(6, 8'h00);
        release_reset();
        run_instrs(3);
        chk("skz1_pc", pc_out, 6);

        // JMP 30, XOR 31, HLT at 31 with pc wrap.
        do_reset();
        clear_mem();
        load(0, 8'hFE); load(30, 8'h9F); load(31, 8'h00);
        release_reset();
        run_instrs(5);
        chk("wrap_acc", acc_out, 0);
        chk("wrap_pc", pc_out, 0);
        chk("wrap_halted", halted, 1);

        // Reset during STO execute must suppress the write.
        do_reset();
        clear_mem();
        load(0, 8'hAD); load(1, 8'hCC); load(13, 8'h55); load(12, 8'h3C);
        release_reset();
        run_instrs(1);
        chk("r5_acc", acc_out, 8'h55);
        @(negedge clock);
        @(negedge clock);
        chk("r5_exec_wr", mem_wr_en, 1);
        reset = 1'b1;
        #1;
        chk("r5_rst_wr", mem_wr_en, 0);
        chk("r5_rst_rd", mem_rd_en, 0);
        @(negedge clock);
        chk("r5_mem12", mem[12], 8'h3C);
        chk("r5_pc", pc_out, 0);
        release_reset();
        run_instrs(2);
        chk("r5_mem12_after", mem[12], 8'h55);

        // Random programs against the reference interpreter.
        for (int p = 0; p < 8; p++) begin
            do_reset();
            for (int i = 0; i < 32; i++) load(i, int'($urandom_range(0, 255)));
            release_reset();
            run_instrs(30);
            mem_compare();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
